// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmds_pkg
// Description : Shared TMDS constants and types: control tokens, ctrl code
//               type and word-aligner state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    localparam logic [9:0] c_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] c_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] c_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] c_TOKEN_11 = 10'b1010101011;

    typedef logic [1:0] ctrl_t;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } align_state_t;

endpackage
`default_nettype wire

// File: rtl/tmds_ctrl_detect.sv
`default_nettype none
// ============================================================================
// Module      : tmds_ctrl_detect
// Description : Combinational TMDS control-token match and {C1,C0} decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_ctrl_detect
    import tmds_pkg::*;
(
    input  logic [9:0] din,
    output logic       is_ctrl,
    output ctrl_t      ctrl
);

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        case (din)
            c_TOKEN_00: ctrl = 2'b00;
            c_TOKEN_01: ctrl = 2'b01;
            c_TOKEN_10: ctrl = 2'b10;
            c_TOKEN_11: ctrl = 2'b11;
            default:    is_ctrl = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tmds_word_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tmds_word_aligner
// Description : Hunts for runs of TMDS control tokens, pulses bitslip until the
//               word boundary is found, then monitors lock. Optional statistics
//               ports are enabled with the TMDS_ALIGN_STATS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int WINDOW    = 4096,
    parameter int TOKEN_RUN = 8,
    parameter int SLIP_WAIT = 16
)(
    input  logic       pclk,
    input  logic       reset,
    input  logic [9:0] din,
    output logic [9:0] dout,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic       bitslip,
    output logic       locked
`ifdef TMDS_ALIGN_STATS_EN
    ,
    output logic [3:0] slip_cnt,
    output logic [7:0] loss_cnt
`endif
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    align_state_t      r_state, w_state_next;
    logic [5:0]        r_run, w_run_next;
    logic [WIN_W-1:0]  r_win, w_win_next;
    logic [WAIT_W-1:0] r_wait, w_wait_next;
    logic              r_seen, w_seen_next;
    logic [3:0]        r_slip_pos, w_slip_pos_next;

    logic [9:0]        r_dout;
    logic              r_is_ctrl;
    ctrl_t             r_ctrl;
    logic              r_bitslip;
    logic              r_locked;

    logic              w_is_tok;
    ctrl_t             w_ctrl;
    logic              w_active;
    logic              w_hit;
    logic              w_expire;
    logic              w_enter;

    tmds_ctrl_detect u_detect (
        .din     (din),
        .is_ctrl (w_is_tok),
        .ctrl    (w_ctrl)
    );

    // Token evidence and window timing only matter while the boundary is stable.
    assign w_active = (r_state == SEARCH) || (r_state == LOCKED);
    assign w_hit    = w_active && w_is_tok && (r_run == 6'(TOKEN_RUN - 1));
    assign w_expire = w_active && (r_win == WIN_W'(WINDOW - 1));

    always_comb begin
        w_state_next    = r_state;
        w_seen_next     = r_seen;
        w_slip_pos_next = r_slip_pos;
        case (r_state)
            SEARCH: begin
                if (w_hit) begin
                    w_state_next = LOCKED;
                end else if (w_expire) begin
                    w_state_next = SLIP;
                end
            end
            SLIP: begin
                w_slip_pos_next = (r_slip_pos == 4'd9) ? 4'd0 : r_slip_pos + 4'd1;
                w_state_next    = WAIT;
            end
            WAIT: begin
                if (r_wait == WAIT_W'(SLIP_WAIT - 1)) begin
                    w_state_next = SEARCH;
                end
            end
            LOCKED: begin
                if (w_hit) begin
                    w_seen_next = 1'b1;
                end
                if (w_expire) begin
                    w_seen_next = 1'b0;
                    if (!(r_seen || w_hit)) begin
                        w_state_next = SEARCH;
                    end
                end
            end
            default: w_state_next = SEARCH;
        endcase

        w_enter = (w_state_next != r_state);
        if (w_enter) begin
            w_seen_next = 1'b0;
        end

        w_run_next = 6'd0;
        if (!w_enter && w_active && w_is_tok) begin
            w_run_next = (r_run == 6'(TOKEN_RUN)) ? r_run : r_run + 6'd1;
        end

        // WINDOW is a power of two, so the window counter wraps on its own.
        w_win_next = '0;
        if (!w_enter && w_active) begin
            w_win_next = r_win + WIN_W'(1);
        end

        w_wait_next = '0;
        if (!w_enter && (r_state == WAIT)) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state    <= SEARCH;
            r_run      <= '0;
            r_win      <= '0;
            r_wait     <= '0;
            r_seen     <= 1'b0;
            r_slip_pos <= '0;
            r_dout     <= '0;
            r_is_ctrl  <= 1'b0;
            r_ctrl     <= '0;
            r_bitslip  <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_run      <= w_run_next;
            r_win      <= w_win_next;
            r_wait     <= w_wait_next;
            r_seen     <= w_seen_next;
            r_slip_pos <= w_slip_pos_next;
            r_dout     <= din;
            r_is_ctrl  <= w_is_tok;
            r_ctrl     <= w_ctrl;
            r_bitslip  <= (w_state_next == SLIP);
            r_locked   <= (w_state_next == LOCKED);
        end
    end

    assign dout    = r_dout;
    assign is_ctrl = r_is_ctrl;
    assign ctrl    = r_ctrl;
    assign bitslip = r_bitslip;
    assign locked  = r_locked;

`ifdef TMDS_ALIGN_STATS_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_loss_cnt <= '0;
        end else if ((r_state == LOCKED) && (w_state_next == SEARCH) && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign slip_cnt = r_slip_pos;
    assign loss_cnt = r_loss_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/tmds_word_aligner.md
# tmds_word_aligner

Receive-side word aligner for the HDMI/TMDS path. It runs in the pixel-clock domain behind the 10:1 deserializer, whose word clock comes from the divide-by-5 CLKDIV. It hunts for runs of TMDS control tokens and pulses `bitslip` into the deserializer/CLKDIV calibration input until word boundaries are correct. It then reports lock and monitors the stream, re-entering search when lock is lost.

## Interface
- `WINDOW`, default 4096: words examined per search/monitor window; power of two, ≥ 64.
- `TOKEN_RUN`, default 8: consecutive control tokens that qualify as alignment evidence; range 2..63.
- `SLIP_WAIT`, default 16: settle cycles after each bitslip pulse; ≥ 1.
- `pclk`, input, 1: pixel (word) clock; the only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `din`, input, 10: raw deserialized word, one per `pclk`.
- `dout`, output, 10: `din` registered.
- `is_ctrl`, output, 1: `dout` is one of the four control tokens.
- `ctrl`, output, 2: decoded {C1,C0} when `is_ctrl`; otherwise 0.
- `bitslip`, output, 1: single-cycle pulse to the deserializer CALIB.
- `locked`, output, 1: alignment achieved.
- `slip_cnt`, output, 4: current slip position 0..9 (only with `TMDS_ALIGN_STATS_EN`).
- `loss_cnt`, output, 8: lock-loss events, saturating (only with `TMDS_ALIGN_STATS_EN`).

## Operation
- Control tokens map as follows: 10'b1101010100→00, 10'b0010101011→01, 10'b0101010100→10, 10'b1010101011→11.
- `run`, 6 bits: increments on a token and saturates at `TOKEN_RUN`. Any non-token word clears it to 0. It is cleared on every state entry.
- `hit` = `run` reaches `TOKEN_RUN` this cycle (the Nth consecutive token).
- `win`: counts words 0..`WINDOW`-1 in SEARCH and LOCKED. It clears on state entry. When `win` = `WINDOW`-1, the window expires.
- State machine:
  - SEARCH: `hit` → LOCKED. Window expiry without `hit` → SLIP.
  - SLIP: one cycle, `bitslip`=1. `slip_pos` increments and wraps 9→0. Next state is WAIT.
  - WAIT: counts `SLIP_WAIT` cycles, ignoring `din` and holding `run` at 0, then → SEARCH.
  - LOCKED: `seen` flag is set by `hit`. On window expiry: if `seen` or `hit` this cycle, clear `seen` and stay; otherwise → SEARCH, `locked` drops, and `loss_cnt` increments.
- Simultaneous `hit` and window expiry:
  - In SEARCH, lock wins.
  - In LOCKED, the window counts as seen.
- No lock after 10 slips: the search keeps cycling. `slip_pos` wraps and there is no terminal failure state.
- Reset mid-operation: state → SEARCH and all counters → 0. No `bitslip` pulse is emitted in the reset cycle or the cycle after it.

## Timing
- Reset values:
  - `dout`=0, `is_ctrl`=0, `ctrl`=0, `bitslip`=0, `locked`=0.
  - `slip_cnt`=0, `loss_cnt`=0.
- `dout`, `is_ctrl` and `ctrl` have a 1-cycle latency from `din`.
- `locked` rises on the cycle after the `hit` cycle. It falls on the cycle after the failing window expiry.
- `bitslip` is high for exactly one cycle. It is high in the cycle after SEARCH window expiry.
- Minimum spacing between `bitslip` pulses is 1 + `SLIP_WAIT` + `WINDOW` cycles.
- All outputs are registered. There are no combinational paths from `din`.

## Configuration
- `TMDS_ALIGN_STATS_EN` defined: the `slip_cnt` and `loss_cnt` ports exist.
  - `slip_cnt` mirrors `slip_pos`.
  - `loss_cnt` saturates at 255. Only `reset` clears it.
- Undefined: both ports and `loss_cnt` are absent. The internal `slip_pos` remains, because it is needed for wrap behaviour. Alignment behaviour is identical in both builds.

## Structure
- Shared package `tmds_pkg`:
  - four token constants;
  - state enum `align_state_t` {SEARCH, SLIP, WAIT, LOCKED};
  - 2-bit ctrl typedef.
- Sub-module `tmds_ctrl_detect`: combinational token match and `ctrl` decode. It is shared with the future TMDS decoder.
- Top level holds the FSM, counters and output registers.

## Test plan
1. Reset release, then `din` = 10'b1101010100 for 8 cycles:
   - `locked` = 1 at cycle 9 after the first token;
   - no `bitslip` pulse.
2. Random non-token data, `WINDOW`=64, `SLIP_WAIT`=4:
   - `bitslip` pulses every 69 cycles;
   - `slip_cnt` steps 1..9, then 0.
3. Token stream rotated by 3 bits, deserializer model honouring `bitslip`:
   - lock after exactly 3 pulses;
   - `slip_cnt`=3.
4. While locked, feed 2×`WINDOW` random words:
   - `locked` falls after the first tokenless window;
   - `loss_cnt`=1.
5. Seven tokens followed by one non-token, repeated: never locks.
6. Assert `reset` in the WAIT state:
   - next cycle all outputs are at reset values;
   - the search restarts with a full window.
